// File: rtl/digit_scan_if.sv
// Handshake bundle between the scan controller and the display driver:
// scan enable and digit mask in, digit select / anodes / frame status out.
interface digit_scan_if;
    logic       en;
    logic [3:0] digit_en;
    logic [3:0] sel;
    logic [3:0] an;
    logic [1:0] dig_idx;
    logic       frame_done;

    modport master (
        output en, digit_en,
        input  sel, an, dig_idx, frame_done
    );

    modport slave (
        input  en, digit_en,
        output sel, an, dig_idx, frame_done
    );
endinterface

// File: rtl/digit_scan_ctrl.sv
// Time-multiplexing scan controller for a 4-digit seven-segment display.
// Each digit slot is a dark BLANK gap followed by a lit SHOW period.
module digit_scan_ctrl #(
    parameter int SHOW_CYCLES  = 99000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic         clk,
    input  logic         rst,
    digit_scan_if.slave  bus
);

    localparam int MAX_CYC = (SHOW_CYCLES > BLANK_CYCLES) ? SHOW_CYCLES : BLANK_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SHOW_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       cur_sel;
    logic [3:0]       cur_an;
    logic [1:0]       cur_idx;
    logic             frame_pulse;
    logic [3:0]       show_sel;

    function automatic logic [3:0] onehot(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

    // A masked digit still gets its whole slot, just dark, so frame timing never changes.
    always_comb begin
        show_sel = onehot(cur_idx) & {4{bus.digit_en[cur_idx]}};
    end

    always_ff @(posedge clk) begin
        if (rst || !bus.en) begin
            state       <= IDLE;
            cnt         <= '0;
            cur_idx     <= 2'd0;
            cur_sel     <= 4'b0000;
            cur_an      <= 4'b1111;
            frame_pulse <= 1'b0;
        end else begin
            frame_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    state   <= BLANK;
                    cnt     <= '0;
                    cur_idx <= 2'd0;
                    cur_sel <= 4'b0000;
                    cur_an  <= 4'b1111;
                end
                BLANK: begin
                    if (cnt == BLANK_LAST) begin
                        state   <= SHOW;
                        cnt     <= '0;
                        cur_sel <= show_sel;
                        cur_an  <= ~show_sel;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                SHOW: begin
                    if (cnt == SHOW_LAST) begin
                        state       <= BLANK;
                        cnt         <= '0;
                        cur_sel     <= 4'b0000;
                        cur_an      <= 4'b1111;
                        cur_idx     <= cur_idx + 2'd1;
                        frame_pulse <= (cur_idx == 2'd3);
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    cnt     <= '0;
                    cur_idx <= 2'd0;
                    cur_sel <= 4'b0000;
                    cur_an  <= 4'b1111;
                end
            endcase
        end
    end

    assign bus.sel        = cur_sel;
    assign bus.an         = cur_an;
    assign bus.dig_idx    = cur_idx;
    assign bus.frame_done = frame_pulse;

endmodule
